// File: rtl/skein_mix_pipe.sv
// ---------------------------------------------------------------------------
// Module   : skein_mix_pipe (+ rotator_constant)
// Purpose  : Two-stage Threefish MIX/unMIX pipeline with valid/ready flow.
// Options  : SKEIN_MIX_INVERSE_EN adds inv_i and the per-beat unMIX path.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rotator_constant (
  input  logic [2:0] d_i,
  input  logic [2:0] j_i,
  output logic [5:0] r_o
);
  // Threefish-1024 rotation table, indexed by {d, j}.
  localparam logic [5:0] ROT_TABLE [64] = '{
    6'd24, 6'd13, 6'd8,  6'd47, 6'd8,  6'd17, 6'd22, 6'd37,
    6'd38, 6'd19, 6'd10, 6'd55, 6'd49, 6'd18, 6'd23, 6'd52,
    6'd33, 6'd4,  6'd51, 6'd13, 6'd34, 6'd41, 6'd59, 6'd17,
    6'd5,  6'd20, 6'd48, 6'd41, 6'd47, 6'd28, 6'd16, 6'd25,
    6'd41, 6'd9,  6'd37, 6'd31, 6'd12, 6'd47, 6'd44, 6'd30,
    6'd16, 6'd34, 6'd56, 6'd51, 6'd4,  6'd53, 6'd42, 6'd41,
    6'd31, 6'd44, 6'd47, 6'd46, 6'd19, 6'd42, 6'd44, 6'd25,
    6'd9,  6'd48, 6'd35, 6'd52, 6'd23, 6'd31, 6'd37, 6'd20
  };

  assign r_o = ROT_TABLE[{d_i, j_i}];
endmodule

module skein_mix_pipe #(
  parameter int WORD_W = 64,
  parameter int TAG_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] x0_i,
  input  logic [WORD_W-1:0] x1_i,
  input  logic [2:0]        d_i,
  input  logic [2:0]        j_i,
  input  logic [TAG_W-1:0]  tag_i,
`ifdef SKEIN_MIX_INVERSE_EN
  input  logic              inv_i,
`endif
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] y0_o,
  output logic [WORD_W-1:0] y1_o,
  output logic [TAG_W-1:0]  tag_o
);
  localparam logic [5:0] ROT_MASK = 6'(WORD_W - 1);

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                             input logic [5:0] r);
    logic [2*WORD_W-1:0] dbl;
    dbl = {x, x} << r;
    return dbl[2*WORD_W-1:WORD_W];
  endfunction

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input logic [5:0] r);
    logic [2*WORD_W-1:0] dbl;
    dbl = {x, x} >> r;
    return dbl[WORD_W-1:0];
  endfunction

  logic [5:0] rot_const;

  rotator_constant u_rot (
    .d_i (d_i),
    .j_i (j_i),
    .r_o (rot_const)
  );

  // S1: a = sum (fwd) or y0 (inv); b = x1 (fwd) or x1^x0 (inv)
  logic              s1_valid_q, s1_valid_d;
  logic [WORD_W-1:0] s1_a_q, s1_a_d;
  logic [WORD_W-1:0] s1_b_q, s1_b_d;
  logic [5:0]        s1_r_q, s1_r_d;
  logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
  logic              s2_valid_q, s2_valid_d;
  logic [WORD_W-1:0] y0_q, y0_d;
  logic [WORD_W-1:0] y1_q, y1_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
`ifdef SKEIN_MIX_INVERSE_EN
  logic              s1_inv_q, s1_inv_d;
`endif

  logic              s2_adv;
  logic              s1_load;
  logic [WORD_W-1:0] s2_y0, s2_y1;

  assign s2_adv     = !s2_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s2_adv;
  assign s1_load    = in_valid_i && in_ready_o;

  always_comb begin
    s2_y0 = s1_a_q;
    s2_y1 = rotl(s1_b_q, s1_r_q) ^ s1_a_q;
`ifdef SKEIN_MIX_INVERSE_EN
    if (s1_inv_q) begin
      s2_y1 = rotr(s1_b_q, s1_r_q);
      s2_y0 = s1_a_q - s2_y1;
    end
`endif
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_r_d     = s1_r_q;
    s1_tag_d   = s1_tag_q;
`ifdef SKEIN_MIX_INVERSE_EN
    s1_inv_d   = s1_inv_q;
`endif
    s2_valid_d = s2_valid_q;
    y0_d       = y0_q;
    y1_d       = y1_q;
    tag_d      = tag_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_a_d     = x0_i + x1_i;
      s1_b_d     = x1_i;
      s1_r_d     = rot_const & ROT_MASK;
      s1_tag_d   = tag_i;
`ifdef SKEIN_MIX_INVERSE_EN
      s1_inv_d   = inv_i;
      if (inv_i) begin
        s1_a_d = x0_i;
        s1_b_d = x1_i ^ x0_i;
      end
`endif
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    // Data registers only move when a real beat enters, keeping them stable otherwise.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y0_d  = s2_y0;
        y1_d  = s2_y1;
        tag_d = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_r_q     <= '0;
      s1_tag_q   <= '0;
`ifdef SKEIN_MIX_INVERSE_EN
      s1_inv_q   <= 1'b0;
`endif
      s2_valid_q <= 1'b0;
      y0_q       <= '0;
      y1_q       <= '0;
      tag_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_r_q     <= s1_r_d;
      s1_tag_q   <= s1_tag_d;
`ifdef SKEIN_MIX_INVERSE_EN
      s1_inv_q   <= s1_inv_d;
`endif
      s2_valid_q <= s2_valid_d;
      y0_q       <= y0_d;
      y1_q       <= y1_d;
      tag_q      <= tag_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign y0_o        = y0_q;
  assign y1_o        = y1_q;
  assign tag_o       = tag_q;
endmodule

`default_nettype wire

// File: tb/tb_skein_mix_pipe.sv
// ---------------------------------------------------------------------------
// Module   : tb_skein_mix_pipe
// Purpose  : Scoreboard bench for skein_mix_pipe (64-bit and 32-bit builds).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_skein_mix_pipe;
  localparam int RC [64] = '{
    24, 13, 8,  47, 8,  17, 22, 37,
    38, 19, 10, 55, 49, 18, 23, 52,
    33, 4,  51, 13, 34, 41, 59, 17,
    5,  20, 48, 41, 47, 28, 16, 25,
    41, 9,  37, 31, 12, 47, 44, 30,
    16, 34, 56, 51, 4,  53, 42, 41,
    31, 44, 47, 46, 19, 42, 44, 25,
    9,  48, 35, 52, 23, 31, 37, 20
  };

  typedef struct {
    logic [63:0] y0;
    logic [63:0] y1;
    logic [7:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] x0 = '0, x1 = '0;
  logic [2:0]  d = '0, j = '0;
  logic [7:0]  tag = '0;
  logic        inv = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] y0, y1;
  logic [7:0]  tag_out;

  logic        iv32 = 1'b0;
  logic        ir32;
  logic [31:0] a32 = '0, b32 = '0;
  logic [2:0]  d32 = '0, j32 = '0;
  logic        ov32;
  logic [31:0] y0_32, y1_32;
  logic [7:0]  t32;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  exp_t        sb[$];
  logic [7:0]  log_tag[$];
  int          log_cyc[$];
  logic [63:0] orig_x0 = '0, orig_x1 = '0;
  bit          rand_done = 0;

  always #5 clk = ~clk;

  skein_mix_pipe #(.WORD_W(64), .TAG_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .x0_i(x0), .x1_i(x1), .d_i(d), .j_i(j), .tag_i(tag),
`ifdef SKEIN_MIX_INVERSE_EN
    .inv_i(inv),
`endif
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .y0_o(y0), .y1_o(y1), .tag_o(tag_out)
  );

  skein_mix_pipe #(.WORD_W(32), .TAG_W(8)) dut32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv32), .in_ready_o(ir32),
    .x0_i(a32), .x1_i(b32), .d_i(d32), .j_i(j32), .tag_i(8'h00),
`ifdef SKEIN_MIX_INVERSE_EN
    .inv_i(1'b0),
`endif
    .out_valid_o(ov32), .out_ready_i(1'b1),
    .y0_o(y0_32), .y1_o(y1_32), .tag_o(t32)
  );

  // Reference: plain add, rotate via shifts, xor, using the 64-bit table.
  function automatic exp_t fwd_model(input logic [63:0] a, input logic [63:0] b,
                                     input logic [2:0] dd, input logic [2:0] jj,
                                     input logic [7:0] tg);
    exp_t e;
    int r;
    logic [63:0] rl;
    r  = RC[int'(dd) * 8 + int'(jj)] % 64;
    rl = (r == 0) ? b : ((b << r) | (b >> (64 - r)));
    e.y0  = a + b;
    e.y1  = rl ^ e.y0;
    e.tag = tg;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_t e;
      e = fwd_model(x0, x1, d, j, tag);
`ifdef SKEIN_MIX_INVERSE_EN
      if (inv) begin
        e.y0 = orig_x0;
        e.y1 = orig_x1;
      end
`endif
      sb.push_back(e);
      acc_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got tag %h want no beat", tag_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_y0", y0, e.y0);
        check("sb_y1", y1, e.y1);
        check("sb_tag", {56'd0, tag_out}, {56'd0, e.tag});
      end
      log_tag.push_back(tag_out);
      log_cyc.push_back(cyc);
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [2:0] dd,
                      input logic [2:0] jj, input logic [7:0] tg, input logic iv);
    int  n;
    logic acc;
    x0 = a; x1 = b; d = dd; j = jj; tag = tg; inv = iv; in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout: got no accept want accept tag %h", tg);
        acc = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Beat presented and captured at one edge; valid after the following edge.
  task automatic directed(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [2:0] dd, input logic [2:0] jj, input logic [7:0] tg,
                          input logic [63:0] ey0, input logic [63:0] ey1);
    send(a, b, dd, jj, tg, 1'b0);
    check({name, "_valid_early"}, {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    check({name, "_y0"}, y0, ey0);
    check({name, "_y1"}, y1, ey1);
    check({name, "_tag"}, {56'd0, tag_out}, {56'd0, tg});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_y0", y0, 64'd0);
    check("rst_y1", y1, 64'd0);
    check("rst_tag", {56'd0, tag_out}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst = 1'b0;

    directed("d00_ones", 64'd1, 64'd1, 3'd0, 3'd0, 8'h11,
             64'h0000000000000002, 64'h0000000001000002);
    directed("d00_wrap", 64'd0, 64'h8000000000000000, 3'd0, 3'd0, 8'h12,
             64'h8000000000000000, 64'h8000000000800000);
    directed("d70_ovf", 64'hFFFFFFFFFFFFFFFF, 64'd1, 3'd7, 3'd0, 8'h13,
             64'd0, 64'h200);
    drain();

    // 32-bit build: constant 47 reduces to 15.
    a32 = 32'd0; b32 = 32'd1; d32 = 3'd0; j32 = 3'd3; iv32 = 1'b1;
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    @(posedge clk);
    #1;
    check("w32_valid", {63'd0, ov32}, 64'd1);
    check("w32_y0", {32'd0, y0_32}, 64'd1);
    check("w32_y1", {32'd0, y1_32}, 64'h8001);

    // Backpressure: four tagged beats against a 5-cycle stall.
    log_tag.delete();
    log_cyc.delete();
    out_ready = 1'b0;
    begin
      int base;
      base = acc_cnt;
      fork
        begin
          for (int t = 1; t <= 4; t++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom), 3'($urandom),
                 8'(t), 1'b0);
        end
        begin
          logic        have;
          logic [63:0] hy0, hy1;
          logic [7:0]  htg;
          have = 1'b0;
          hy0 = '0; hy1 = '0; htg = '0;
          for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) begin
              if (!have) begin
                have = 1'b1;
                hy0 = y0; hy1 = y1; htg = tag_out;
              end else begin
                check("stall_hold_y0", y0, hy0);
                check("stall_hold_y1", y1, hy1);
                check("stall_hold_tag", {56'd0, tag_out}, {56'd0, htg});
              end
            end
          end
          check("stall_accepts", 64'(acc_cnt - base), 64'd2);
          check("stall_in_ready", {63'd0, in_ready}, 64'd0);
          check("stall_valid", {63'd0, out_valid}, 64'd1);
          @(posedge clk);
          #1;
          out_ready = 1'b1;
        end
      join
    end
    drain();
    check("stall_count", 64'(log_tag.size()), 64'd4);
    if (log_tag.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("stall_order", {56'd0, log_tag[k]}, 64'(k + 1));
        if (k > 0) check("stall_spacing", 64'(log_cyc[k] - log_cyc[k-1]), 64'd1);
      end
    end

    // Random traffic with random backpressure.
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom), 3'($urandom),
               8'($urandom), 1'b0);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

`ifdef SKEIN_MIX_INVERSE_EN
    // Round trip: forward result from the DUT is fed back as an unMIX beat.
    for (int i = 0; i < 256; i++) begin
      logic [63:0] a, b, fy0, fy1;
      int n;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      send(a, b, 3'(i / 8 % 8), 3'(i % 8), 8'(i), 1'b0);
      n = 0;
      fy0 = '0; fy1 = '0;
      while (n < 20) begin
        @(negedge clk);
        if (out_valid) begin
          fy0 = y0;
          fy1 = y1;
          n = 100;
        end else begin
          n++;
        end
      end
      if (n != 100) begin
        total++;
        bad++;
        $display("FAIL inv_fwd_timeout: got no output want output %0d", i);
      end
      @(posedge clk);
      #1;
      orig_x0 = a;
      orig_x1 = b;
      send(fy0, fy1, 3'(i / 8 % 8), 3'(i % 8), 8'(i), 1'b1);
    end
    drain();
`endif

    // Reset with both stages occupied.
    out_ready = 1'b0;
    send(64'h1234, 64'h5678, 3'd2, 3'd5, 8'h21, 1'b0);
    send(64'h9abc, 64'hdef0, 3'd3, 3'd6, 8'h22, 1'b0);
    check("full_valid", {63'd0, out_valid}, 64'd1);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_y0", y0, 64'd0);
    check("mid_rst_y1", y1, 64'd0);
    check("mid_rst_tag", {56'd0, tag_out}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("post_rst_no_stale", 64'(seen), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
